// File: rtl/spi_slave.sv
// spi_slave: SPI responder on the sclk domain; deserialises MOSI into SDO words and
// serialises a held SDS response word onto MISO, with underrun/abort reporting.
module spi_slave #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] SDS,
  input  logic                  SDS_valid,
  output logic                  SDS_ready,
  output logic [DATA_WIDTH-1:0] SDO,
  output logic                  SDO_valid,
  output logic                  underrun,
  output logic                  abort
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int OB = MSB_FIRST ? DATA_WIDTH - 1 : 0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  bit_cnt, bit_cnt_d;
  logic [W-1:0]   rx_shift, rx_d, tx_shift, tx_d, hold, hold_d, sdo_d;
  logic [W-1:0]   rx_next, tx_next;
  logic           hold_full, hold_full_d, tx_loaded, tx_loaded_d;
  logic           sdo_valid_d, underrun_d, abort_d;
  logic           accept, move, last;

  assign rx_next   = MSB_FIRST ? {rx_shift[W-2:0], MOSI} : {MOSI, rx_shift[W-1:1]};
  assign tx_next   = MSB_FIRST ? {tx_shift[W-2:0], 1'b0} : {1'b0, tx_shift[W-1:1]};
  assign last      = bit_cnt == CW'(W - 1);
  assign accept    = SDS_valid & ~hold_full;
  assign SDS_ready = ~hold_full;
  assign MISO      = CS ? 1'b0 : tx_shift[OB];

  // tx_loaded marks that tx_shift holds a word not yet started on the wire
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    rx_d        = rx_shift;
    tx_d        = tx_shift;
    tx_loaded_d = tx_loaded;
    sdo_d       = SDO;
    sdo_valid_d = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    move        = 1'b0;
    if (state == IDLE) begin
      if (!CS) begin
        state_d     = SHIFT;
        rx_d        = rx_next;
        bit_cnt_d   = CW'(1);
        tx_d        = tx_loaded ? tx_next : '0;
        tx_loaded_d = 1'b0;
        underrun_d  = ~tx_loaded;
      end else if (hold_full && !tx_loaded) begin
        tx_d        = hold;
        tx_loaded_d = 1'b1;
        move        = 1'b1;
      end
    end else if (!CS) begin
      rx_d = rx_next;
      if (last) begin
        bit_cnt_d   = '0;
        sdo_d       = rx_next;
        sdo_valid_d = 1'b1;
        tx_d        = hold_full ? hold : '0;
        tx_loaded_d = hold_full;
        move        = hold_full;
        underrun_d  = ~hold_full;
      end else begin
        bit_cnt_d = bit_cnt + CW'(1);
        tx_d      = tx_next;
      end
    end else begin
      state_d = IDLE;
      if (bit_cnt != '0) begin
        abort_d     = 1'b1;
        bit_cnt_d   = '0;
        rx_d        = '0;
        tx_d        = '0;
        tx_loaded_d = 1'b0;
      end
    end
    hold_d      = accept ? SDS : hold;
    hold_full_d = accept | (hold_full & ~move);
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_loaded <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      SDO       <= '0;
      SDO_valid <= 1'b0;
      underrun  <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      rx_shift  <= rx_d;
      tx_shift  <= tx_d;
      tx_loaded <= tx_loaded_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      SDO       <= sdo_d;
      SDO_valid <= sdo_valid_d;
      underrun  <= underrun_d;
      abort     <= abort_d;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of spi_slave in MSB-first (d0) and LSB-first (d1) builds.
module tb_spi_slave;
  logic       sclk = 1'b0, reset = 1'b0, CS = 1'b1, MOSI = 1'b0, SDS_valid = 1'b0;
  logic [7:0] SDS = 8'h00;
  logic       miso0, rdy0, sv0, ur0, ab0, miso1, rdy1, sv1, ur1, ab1;
  logic [7:0] sdo0, sdo1;
  int         checks = 0, errors = 0;

  always #5 sclk = ~sclk;

  spi_slave #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) d0 (
    .sclk(sclk), .reset(reset), .CS(CS), .MOSI(MOSI), .MISO(miso0), .SDS(SDS),
    .SDS_valid(SDS_valid), .SDS_ready(rdy0), .SDO(sdo0), .SDO_valid(sv0),
    .underrun(ur0), .abort(ab0));

  spi_slave #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) d1 (
    .sclk(sclk), .reset(reset), .CS(CS), .MOSI(MOSI), .MISO(miso1), .SDS(SDS),
    .SDS_valid(SDS_valid), .SDS_ready(rdy1), .SDO(sdo1), .SDO_valid(sv1),
    .underrun(ur1), .abort(ab1));

  task automatic tick;
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic do_reset;
    reset = 1'b0; CS = 1'b1; MOSI = 1'b0; SDS_valid = 1'b0;
    tick; tick;
    reset = 1'b1;
  endtask

  task automatic load(input logic [7:0] w);
    SDS = w; SDS_valid = 1'b1;
    tick;
    SDS_valid = 1'b0;
  endtask

  // drives n bits (w[7] first) with CS low; m0 collects d0 MISO MSB-first, m1 d1 MISO LSB-first
  task automatic shift_word(input logic [7:0] w, input int n, output logic [7:0] m0,
                            output logic [7:0] m1, output int urs, output int svs);
    m0 = '0; m1 = '0; urs = 0; svs = 0;
    for (int i = 0; i < n; i++) begin
      CS = 1'b0; MOSI = w[7-i];
      #1;
      m0 = {m0[6:0], miso0};
      m1 = {miso1, m1[7:1]};
      urs += int'(ur0);
      svs += int'(sv0);
      @(posedge sclk);
      @(negedge sclk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] m0, m1;
    int urs, svs;
    do_reset;
    load(8'hAA); tick; load(8'h55);
    shift_word(8'hFF, 8, m0, m1, urs, svs);
    shift_word(8'hFF, 3, m0, m1, urs, svs);
    reset = 1'b0;
    #1;
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso0); end
    checks++; if (sdo0 !== 8'h00) begin errors++; $display("FAIL reset_sdo got %h exp 00", sdo0); end
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL reset_sdo_valid got %b exp 0", sv0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy0); end
    checks++; if (ur0 !== 1'b0 || ab0 !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", ur0, ab0); end
    CS = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    checks++; if (ab0 !== 1'b0) begin errors++; $display("FAIL reset_idle_abort got %b exp 0", ab0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %b exp 1", rdy0); end
  endtask

  task automatic test_basic;
    logic [7:0] m0, m1;
    int urs, svs;
    do_reset;
    load(8'hA5);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b exp 0", rdy0); end
    tick;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL basic_ready_rise got %b exp 1", rdy0); end
    shift_word(8'h3C, 8, m0, m1, urs, svs);
    checks++; if (m0 !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h exp a5", m0); end
    checks++; if (urs !== 0 || svs !== 0) begin errors++; $display("FAIL basic_midframe_pulses got ur=%0d sv=%0d exp 0 0", urs, svs); end
    checks++; if (sdo0 !== 8'h3C) begin errors++; $display("FAIL basic_sdo got %h exp 3c", sdo0); end
    checks++; if (sv0 !== 1'b1) begin errors++; $display("FAIL basic_sdo_valid got %b exp 1", sv0); end
    CS = 1'b1;
    #1;
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL basic_miso_cs_high got %b exp 0", miso0); end
    tick;
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL basic_sdo_valid_pulse got %b exp 0", sv0); end
    checks++; if (ab0 !== 1'b0) begin errors++; $display("FAIL basic_quiet_end got %b exp 0", ab0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] m0, m1;
    int urs, svs, urs2, svs2;
    do_reset;
    load(8'h11); tick; load(8'h22);
    shift_word(8'hF0, 8, m0, m1, urs, svs);
    checks++; if (m0 !== 8'h11) begin errors++; $display("FAIL b2b_miso1 got %h exp 11", m0); end
    checks++; if (sdo0 !== 8'hF0 || sv0 !== 1'b1) begin errors++; $display("FAIL b2b_sdo1 got %h/%b exp f0/1", sdo0, sv0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_reload got %b exp 1", rdy0); end
    SDS = 8'h33; SDS_valid = 1'b1;
    shift_word(8'h0F, 8, m0, m1, urs2, svs2);
    SDS_valid = 1'b0;
    checks++; if (m0 !== 8'h22) begin errors++; $display("FAIL b2b_miso2 got %h exp 22", m0); end
    checks++; if (sdo0 !== 8'h0F || sv0 !== 1'b1) begin errors++; $display("FAIL b2b_sdo2 got %h/%b exp 0f/1", sdo0, sv0); end
    checks++; if (svs + svs2 !== 1) begin errors++; $display("FAIL b2b_valid_count got %0d exp 1", svs + svs2); end
    checks++; if (urs + urs2 !== 0 || ur0 !== 1'b0) begin errors++; $display("FAIL b2b_underrun got %0d/%b exp 0/0", urs + urs2, ur0); end
    CS = 1'b1;
    tick;
  endtask

  task automatic test_underrun;
    logic [7:0] m0, m1;
    int urs, svs;
    do_reset;
    shift_word(8'hA5, 8, m0, m1, urs, svs);
    checks++; if (m0 !== 8'h00) begin errors++; $display("FAIL underrun_miso got %h exp 00", m0); end
    checks++; if (urs !== 1) begin errors++; $display("FAIL underrun_start_count got %0d exp 1", urs); end
    checks++; if (sdo0 !== 8'hA5) begin errors++; $display("FAIL underrun_sdo got %h exp a5", sdo0); end
    CS = 1'b1;
    tick;
  endtask

  task automatic test_abort;
    logic [7:0] m0, m1;
    int urs, svs;
    do_reset;
    shift_word(8'hC3, 8, m0, m1, urs, svs);
    CS = 1'b1;
    tick;
    load(8'h5A); tick;
    shift_word(8'hE0, 3, m0, m1, urs, svs);
    checks++; if (m0 !== 8'h02) begin errors++; $display("FAIL abort_partial_miso got %h exp 02", m0); end
    CS = 1'b1;
    tick;
    checks++; if (ab0 !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b exp 1", ab0); end
    checks++; if (sdo0 !== 8'hC3 || sv0 !== 1'b0) begin errors++; $display("FAIL abort_sdo_kept got %h/%b exp c3/0", sdo0, sv0); end
    tick;
    checks++; if (ab0 !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b exp 0", ab0); end
    shift_word(8'h96, 8, m0, m1, urs, svs);
    checks++; if (sdo0 !== 8'h96 || sv0 !== 1'b1) begin errors++; $display("FAIL abort_next_frame got %h/%b exp 96/1", sdo0, sv0); end
    checks++; if (m0 !== 8'h00) begin errors++; $display("FAIL abort_no_retransmit got %h exp 00", m0); end
    CS = 1'b1;
    tick;
  endtask

  task automatic test_lsb_first;
    logic [7:0] m0, m1;
    int urs, svs;
    do_reset;
    load(8'h01); tick;
    shift_word(8'h80, 8, m0, m1, urs, svs);
    checks++; if (sdo1 !== 8'h01 || sv1 !== 1'b1) begin errors++; $display("FAIL lsb_sdo got %h/%b exp 01/1", sdo1, sv1); end
    checks++; if (m1[0] !== 1'b1) begin errors++; $display("FAIL lsb_first_miso_bit got %b exp 1", m1[0]); end
    checks++; if (m1 !== 8'h01) begin errors++; $display("FAIL lsb_miso_word got %h exp 01", m1); end
    checks++; if (sdo0 !== 8'h80 || m0 !== 8'h01) begin errors++; $display("FAIL msb_same_stream got sdo=%h miso=%h exp 80 01", sdo0, m0); end
    CS = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_lsb_first;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
